// File: rtl/iigs_mem_arbiter.sv
// ---------------------------------------------------------------------------
// iigs_mem_arbiter
//
// Shares one synchronous external RAM port between the 65C816 bus (CPU
// requester) and the video scanout fetcher (video requester). A CPU write into
// bank $00/$01 that lands in a region enabled by the $C035 shadow register is
// followed by a second write of the same byte into bank $E0/$E1.
//
// Ports:
//   clk_sys_i      system clock
//   reset_n_i      synchronous active-low reset
//   shadow_i       live $C035 value (1 = shadowing inhibited for that region)
//   cpu_req_i      CPU request, held until cpu_ack_o
//   cpu_wr_i       CPU direction, 1 = write
//   cpu_addr_i     CPU {bank, addr}
//   cpu_wdata_i    CPU write data
//   cpu_ack_o      one-cycle CPU completion pulse
//   cpu_rdata_o    CPU read data, valid with cpu_ack_o
//   vid_req_i      video fetch request, held until vid_ack_o
//   vid_addr_i     video address, bit 16 selects $E1 over $E0
//   vid_ack_o      one-cycle video completion pulse
//   vid_rdata_o    video fetch data, valid with vid_ack_o
//   ram_cs_o       RAM access strobe, one cycle per access
//   ram_we_o       RAM write enable, qualified by ram_cs_o
//   ram_addr_o     RAM address
//   ram_wdata_o    RAM write data
//   ram_rdata_i    RAM read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module iigs_mem_arbiter (
    input  logic        clk_sys_i,
    input  logic        reset_n_i,
    input  logic [7:0]  shadow_i,
    input  logic        cpu_req_i,
    input  logic        cpu_wr_i,
    input  logic [23:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic        cpu_ack_o,
    output logic [7:0]  cpu_rdata_o,
    input  logic        vid_req_i,
    input  logic [16:0] vid_addr_i,
    output logic        vid_ack_o,
    output logic [7:0]  vid_rdata_o,
    output logic        ram_cs_o,
    output logic        ram_we_o,
    output logic [23:0] ram_addr_o,
    output logic [7:0]  ram_wdata_o,
    input  logic [7:0]  ram_rdata_i
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CPU_RD  = 3'd1;
    localparam logic [2:0] ST_CPU_WR  = 3'd2;
    localparam logic [2:0] ST_SHD_WR  = 3'd3;
    localparam logic [2:0] ST_VID_RD  = 3'd4;
    localparam logic [2:0] ST_RD_WAIT = 3'd5;
    localparam logic [2:0] ST_ACK     = 3'd6;

    localparam logic GRANT_VID = 1'b0;
    localparam logic GRANT_CPU = 1'b1;

    logic [2:0]  state_q, state_d;
    // Doubles as the owner of the transaction in flight, since it is
    // updated at the moment of grant.
    logic        lastGrant_q, lastGrant_d;
    logic        ramCs_q, ramCs_d;
    logic        ramWe_q, ramWe_d;
    logic [23:0] ramAddr_q, ramAddr_d;
    logic [7:0]  ramWdata_q, ramWdata_d;
    logic        cpuAck_q, cpuAck_d;
    logic        vidAck_q, vidAck_d;
    logic [7:0]  cpuRdata_q, cpuRdata_d;
    logic [7:0]  vidRdata_q, vidRdata_d;

    logic        shadowHit;
    logic        grantCpu;
    logic        grantVid;
    logic        bank00;
    logic        bank01;
    logic        hiresOk;
    logic [15:0] offset;

    // Shadow hit decode for the CPU write currently presented. Only looked at
    // in CPU_WR, which is where the shadow register is sampled.
    always_comb begin
        offset    = cpu_addr_i[15:0];
        bank00    = (cpu_addr_i[23:16] == 8'h00);
        bank01    = (cpu_addr_i[23:16] == 8'h01);
        hiresOk   = bank00 || !shadow_i[4];
        shadowHit = 1'b0;
        if (cpu_wr_i && (bank00 || bank01) && (offset[15:12] != 4'hC)) begin
            if ((offset[15:10] == 6'b000001) && !shadow_i[0]) begin
                shadowHit = 1'b1;
            end
            if ((offset[15:10] == 6'b000010) && !shadow_i[5]) begin
                shadowHit = 1'b1;
            end
            if ((offset[15:13] == 3'b001) && !shadow_i[1] && hiresOk) begin
                shadowHit = 1'b1;
            end
            if ((offset[15:13] == 3'b010) && !shadow_i[2] && hiresOk) begin
                shadowHit = 1'b1;
            end
            if (bank01 && (offset >= 16'h2000) && (offset <= 16'h9FFF) && !shadow_i[3]) begin
                shadowHit = 1'b1;
            end
        end
    end

    // When both are pending, the requester that did not win last time goes.
    always_comb begin
        grantCpu = cpu_req_i && (!vid_req_i || (lastGrant_q == GRANT_VID));
        grantVid = vid_req_i && !grantCpu;
    end

    // Next-state logic. Every output is computed one cycle ahead so it can be
    // driven straight from a register.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        ramCs_d     = 1'b0;
        ramWe_d     = 1'b0;
        ramAddr_d   = ramAddr_q;
        ramWdata_d  = ramWdata_q;
        cpuAck_d    = 1'b0;
        vidAck_d    = 1'b0;
        cpuRdata_d  = cpuRdata_q;
        vidRdata_d  = vidRdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grantCpu) begin
                    lastGrant_d = GRANT_CPU;
                    ramCs_d     = 1'b1;
                    ramAddr_d   = cpu_addr_i;
                    if (cpu_wr_i) begin
                        ramWe_d    = 1'b1;
                        ramWdata_d = cpu_wdata_i;
                        state_d    = ST_CPU_WR;
                    end else begin
                        state_d    = ST_CPU_RD;
                    end
                end else if (grantVid) begin
                    lastGrant_d = GRANT_VID;
                    ramCs_d     = 1'b1;
                    ramAddr_d   = {7'b1110000, vid_addr_i};
                    state_d     = ST_VID_RD;
                end
            end
            ST_CPU_RD, ST_VID_RD: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (lastGrant_q == GRANT_CPU) begin
                    cpuRdata_d = ram_rdata_i;
                    cpuAck_d   = 1'b1;
                end else begin
                    vidRdata_d = ram_rdata_i;
                    vidAck_d   = 1'b1;
                end
                state_d = ST_ACK;
            end
            ST_CPU_WR: begin
                if (shadowHit) begin
                    ramCs_d   = 1'b1;
                    ramWe_d   = 1'b1;
                    ramAddr_d = {7'b1110000, cpu_addr_i[16], cpu_addr_i[15:0]};
                    state_d   = ST_SHD_WR;
                end else begin
                    cpuAck_d  = 1'b1;
                    state_d   = ST_ACK;
                end
            end
            ST_SHD_WR: begin
                cpuAck_d = 1'b1;
                state_d  = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            lastGrant_q <= GRANT_VID;
            ramCs_q     <= 1'b0;
            ramWe_q     <= 1'b0;
            ramAddr_q   <= 24'h000000;
            ramWdata_q  <= 8'h00;
            cpuAck_q    <= 1'b0;
            vidAck_q    <= 1'b0;
            cpuRdata_q  <= 8'h00;
            vidRdata_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            ramCs_q     <= ramCs_d;
            ramWe_q     <= ramWe_d;
            ramAddr_q   <= ramAddr_d;
            ramWdata_q  <= ramWdata_d;
            cpuAck_q    <= cpuAck_d;
            vidAck_q    <= vidAck_d;
            cpuRdata_q  <= cpuRdata_d;
            vidRdata_q  <= vidRdata_d;
        end
    end

    assign cpu_ack_o   = cpuAck_q;
    assign cpu_rdata_o = cpuRdata_q;
    assign vid_ack_o   = vidAck_q;
    assign vid_rdata_o = vidRdata_q;
    assign ram_cs_o    = ramCs_q;
    assign ram_we_o    = ramWe_q;
    assign ram_addr_o  = ramAddr_q;
    assign ram_wdata_o = ramWdata_q;

endmodule

// File: tb/tb_iigs_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iigs_mem_arbiter
//
// Bench for iigs_mem_arbiter. Contains a small RAM model that answers reads
// the cycle after the strobe, a table of directed CPU transactions with hand
// computed expectations, hand-written sequences for reset and alternation, and
// a randomized phase checked against a shadow-region model written from the
// address ranges.
// ---------------------------------------------------------------------------
module tb_iigs_mem_arbiter;

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [7:0]  data;
        logic [7:0]  sh;
        logic [7:0]  shLate;
        int          expAck;
        int          expCs;
        logic [23:0] expA2;
    } vec_t;

    typedef struct {
        int          ackCyc;
        int          ackCnt;
        int          otherAck;
        int          csCnt;
        logic [23:0] a1;
        logic [23:0] a2;
        logic        we1;
        logic        we2;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [7:0]  rd;
    } obs_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic [7:0]  shadow;
    logic        cpuReq;
    logic        cpuWr;
    logic [23:0] cpuAddr;
    logic [7:0]  cpuWdata;
    logic        cpuAck;
    logic [7:0]  cpuRdata;
    logic        vidReq;
    logic [16:0] vidAddr;
    logic        vidAck;
    logic [7:0]  vidRdata;
    logic        ramCs;
    logic        ramWe;
    logic [23:0] ramAddr;
    logic [7:0]  ramWdata;
    logic [7:0]  ramRdata;

    int          checks = 0;
    int          passed = 0;
    logic [23:0] presetAddr = 24'hFFFFFF;
    logic [7:0]  presetData = 8'h00;

    always #5 clk = ~clk;

    iigs_mem_arbiter dut (
        .clk_sys_i   (clk),
        .reset_n_i   (resetN),
        .shadow_i    (shadow),
        .cpu_req_i   (cpuReq),
        .cpu_wr_i    (cpuWr),
        .cpu_addr_i  (cpuAddr),
        .cpu_wdata_i (cpuWdata),
        .cpu_ack_o   (cpuAck),
        .cpu_rdata_o (cpuRdata),
        .vid_req_i   (vidReq),
        .vid_addr_i  (vidAddr),
        .vid_ack_o   (vidAck),
        .vid_rdata_o (vidRdata),
        .ram_cs_o    (ramCs),
        .ram_we_o    (ramWe),
        .ram_addr_o  (ramAddr),
        .ram_wdata_o (ramWdata),
        .ram_rdata_i (ramRdata)
    );

    // RAM contents: one preset location, everything else a hash of the address.
    function automatic logic [7:0] ramValue(input logic [23:0] a);
        if (a == presetAddr) return presetData;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    // Read data appears only in the cycle after a read strobe.
    always @(posedge clk) begin
        ramRdata <= (ramCs && !ramWe) ? ramValue(ramAddr) : 8'h00;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Watches six cycles after a request is raised (the raising cycle is T),
    // recording strobes and acks relative to T. The owner drops its request
    // right at its ack so the DUT sees it low from ack+1.
    task automatic watch(input bit isCpu, input logic [7:0] shLate, output obs_t ob);
        ob = '{default: 0};
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 2) shadow = shLate;
            if (ramCs) begin
                if (ob.csCnt == 0) begin
                    ob.a1 = ramAddr; ob.we1 = ramWe; ob.d1 = ramWdata;
                end else if (ob.csCnt == 1) begin
                    ob.a2 = ramAddr; ob.we2 = ramWe; ob.d2 = ramWdata;
                end
                ob.csCnt++;
            end
            if (isCpu ? vidAck : cpuAck) ob.otherAck++;
            if (isCpu ? cpuAck : vidAck) begin
                ob.ackCnt++;
                if (ob.ackCyc == 0) begin
                    ob.ackCyc = c;
                    ob.rd = isCpu ? cpuRdata : vidRdata;
                end
                if (isCpu) cpuReq = 1'b0;
                else vidReq = 1'b0;
            end
        end
        cpuReq = 1'b0;
        vidReq = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, output obs_t ob);
        cpuWr    = v.wr;
        cpuAddr  = v.addr;
        cpuWdata = v.wr ? v.data : 8'h00;
        shadow   = v.sh;
        cpuReq   = 1'b1;
        watch(1'b1, v.shLate, ob);
    endtask

    task automatic applyVideo(input logic [16:0] va, output obs_t ob);
        vidAddr = va;
        vidReq  = 1'b1;
        watch(1'b0, shadow, ob);
    endtask

    task automatic checkCpu(input string tag, input vec_t v, input obs_t ob);
        checkOutput({tag, ".ackCycle"}, ob.ackCyc, v.expAck);
        checkOutput({tag, ".ackCount"}, ob.ackCnt, 1);
        checkOutput({tag, ".vidAck"}, ob.otherAck, 0);
        checkOutput({tag, ".csCount"}, ob.csCnt, v.expCs);
        checkOutput({tag, ".addr1"}, ob.a1, v.addr);
        checkOutput({tag, ".we1"}, ob.we1, v.wr);
        if (v.wr) checkOutput({tag, ".wdata1"}, ob.d1, v.data);
        else checkOutput({tag, ".rdata"}, ob.rd, v.data);
        if (v.expCs == 2) begin
            checkOutput({tag, ".addr2"}, ob.a2, v.expA2);
            checkOutput({tag, ".we2"}, ob.we2, 1);
            checkOutput({tag, ".wdata2"}, ob.d2, v.data);
        end
    endtask

    task automatic checkVid(input string tag, input logic [16:0] va, input obs_t ob);
        logic [23:0] expAddr;
        expAddr = 24'hE00000 + {7'd0, va};
        checkOutput({tag, ".ackCycle"}, ob.ackCyc, 3);
        checkOutput({tag, ".ackCount"}, ob.ackCnt, 1);
        checkOutput({tag, ".cpuAck"}, ob.otherAck, 0);
        checkOutput({tag, ".csCount"}, ob.csCnt, 1);
        checkOutput({tag, ".addr"}, ob.a1, expAddr);
        checkOutput({tag, ".we"}, ob.we1, 0);
        checkOutput({tag, ".rdata"}, ob.rd, ramValue(expAddr));
    endtask

    // Shadow regions expressed as plain address ranges.
    function automatic bit modelHit(input logic [23:0] a, input logic [7:0] sh);
        int bank;
        int off;
        bit hiresOk;
        bank = int'(a[23:16]);
        off  = int'(a[15:0]);
        if (bank > 1) return 1'b0;
        if (off >= 'hC000 && off <= 'hCFFF) return 1'b0;
        hiresOk = (bank == 0) || !sh[4];
        if (off >= 'h0400 && off <= 'h07FF && !sh[0]) return 1'b1;
        if (off >= 'h0800 && off <= 'h0BFF && !sh[5]) return 1'b1;
        if (off >= 'h2000 && off <= 'h3FFF && !sh[1] && hiresOk) return 1'b1;
        if (off >= 'h4000 && off <= 'h5FFF && !sh[2] && hiresOk) return 1'b1;
        if (bank == 1 && off >= 'h2000 && off <= 'h9FFF && !sh[3]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic vec_t modelVec(input logic wr, input logic [23:0] a, input logic [7:0] wd,
                                      input logic [7:0] sh, input logic [7:0] shLate);
        vec_t v;
        bit hit;
        hit      = wr && modelHit(a, sh);
        v.wr     = wr;
        v.addr   = a;
        v.data   = wr ? wd : ramValue(a);
        v.sh     = sh;
        v.shLate = shLate;
        v.expAck = (wr && !hit) ? 2 : 3;
        v.expCs  = hit ? 2 : 1;
        v.expA2  = hit ? (24'hE00000 + (a & 24'h01FFFF)) : 24'h000000;
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        vec_t        v;
        obs_t        ob;
        string       ackSeq;
        logic [23:0] csQ[$];
        logic [23:0] altAddr[4];
        logic [15:0] offs[18];
        logic [7:0]  banks[5];
        logic [16:0] va;
        logic [23:0] ra;

        offs  = '{16'h0400, 16'h07FF, 16'h0800, 16'h0BFF, 16'h0C00, 16'h03FF,
                  16'h1FFF, 16'h2000, 16'h3FFF, 16'h4000, 16'h5FFF, 16'h6000,
                  16'h9FFF, 16'hA000, 16'hBFFF, 16'hC000, 16'hCFFF, 16'hD000};
        banks = '{8'h00, 8'h01, 8'h02, 8'hE0, 8'hE1};
        altAddr = '{24'h001234, 24'hE10000, 24'h001234, 24'hE10000};

        //               wr    addr        data   sh     shLate ack cs  addr2
        vecs.push_back('{1'b0, 24'h001234, 8'h5A, 8'h00, 8'h00, 3, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h000400, 8'h41, 8'h00, 8'h00, 3, 2, 24'hE00400});
        vecs.push_back('{1'b1, 24'h000400, 8'h41, 8'h01, 8'h01, 2, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h012000, 8'h77, 8'h1E, 8'h1E, 2, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h012000, 8'h77, 8'h16, 8'h16, 3, 2, 24'hE12000});
        vecs.push_back('{1'b1, 24'h000800, 8'h12, 8'h00, 8'h00, 3, 2, 24'hE00800});
        vecs.push_back('{1'b1, 24'h000800, 8'h12, 8'h20, 8'h20, 2, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h00C400, 8'h33, 8'h00, 8'h00, 2, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h013FFF, 8'h44, 8'h00, 8'h00, 3, 2, 24'hE13FFF});
        vecs.push_back('{1'b1, 24'h014000, 8'h55, 8'h10, 8'h10, 3, 2, 24'hE14000});
        vecs.push_back('{1'b1, 24'h019FFF, 8'h66, 8'h08, 8'h08, 2, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h01A000, 8'h67, 8'h00, 8'h00, 2, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h020400, 8'h11, 8'h00, 8'h00, 2, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h0007FF, 8'h22, 8'h00, 8'h00, 3, 2, 24'hE007FF});
        vecs.push_back('{1'b1, 24'h000300, 8'h23, 8'h00, 8'h00, 2, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h005FFF, 8'h24, 8'h14, 8'h14, 2, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h002000, 8'h25, 8'h10, 8'h10, 3, 2, 24'hE02000});
        vecs.push_back('{1'b0, 24'hE10000, 8'h99, 8'h00, 8'h00, 3, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h000400, 8'h41, 8'h00, 8'hFF, 3, 2, 24'hE00400});
        vecs.push_back('{1'b1, 24'h000400, 8'h41, 8'hFF, 8'h00, 2, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h01C000, 8'h5C, 8'h00, 8'h00, 2, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h010400, 8'h31, 8'h01, 8'h01, 2, 1, 24'h000000});
        vecs.push_back('{1'b1, 24'h010400, 8'h31, 8'h00, 8'h00, 3, 2, 24'hE10400});

        // Reset held with both requesters pending.
        resetN     = 1'b0;
        cpuReq     = 1'b1;
        vidReq     = 1'b1;
        cpuWr      = 1'b0;
        cpuAddr    = 24'h001234;
        cpuWdata   = 8'h00;
        vidAddr    = 17'h10000;
        shadow     = 8'h00;
        presetAddr = 24'h001234;
        presetData = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset%0d.ramCs", i), ramCs, 0);
            checkOutput($sformatf("reset%0d.cpuAck", i), cpuAck, 0);
            checkOutput($sformatf("reset%0d.vidAck", i), vidAck, 0);
        end
        checkOutput("reset.ramWe", ramWe, 0);
        checkOutput("reset.ramAddr", ramAddr, 0);
        checkOutput("reset.ramWdata", ramWdata, 0);
        checkOutput("reset.cpuRdata", cpuRdata, 0);
        checkOutput("reset.vidRdata", vidRdata, 0);

        // Both requests held: CPU first, then strict alternation.
        $display("[TB] alternation with both requesters pending");
        resetN = 1'b1;
        ackSeq = "";
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (ramCs) csQ.push_back(ramAddr);
            if (cpuAck) begin
                ackSeq = {ackSeq, "C"};
                checkOutput("alt.cpuRdata", cpuRdata, 8'h5A);
            end
            if (vidAck) begin
                ackSeq = {ackSeq, "V"};
                checkOutput("alt.vidRdata", vidRdata, ramValue(24'hE10000));
            end
        end
        cpuReq = 1'b0;
        vidReq = 1'b0;
        checks++;
        if (ackSeq == "CVCV") passed++;
        else $display("[TB] FAIL alt.order: actual %s required CVCV", ackSeq);
        checkOutput("alt.csCount", csQ.size(), 4);
        for (int i = 0; i < 4 && i < csQ.size(); i++) begin
            checkOutput($sformatf("alt.csAddr%0d", i), csQ[i], altAddr[i]);
        end
        for (int c = 0; c < 6; c++) @(negedge clk);

        // Directed CPU transactions.
        $display("[TB] directed vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            if (!vecs[i].wr) begin
                presetAddr = vecs[i].addr;
                presetData = vecs[i].data;
            end
            applyStimulus(vecs[i], ob);
            checkCpu($sformatf("vec%0d", i), vecs[i], ob);
        end

        // Reset pulse in the middle of a shadow write, then a clean retry.
        $display("[TB] reset during shadow write");
        cpuWr    = 1'b1;
        cpuAddr  = 24'h000400;
        cpuWdata = 8'h41;
        shadow   = 8'h00;
        cpuReq   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst.shdCs", ramCs, 1);
        checkOutput("rst.shdAddr", ramAddr, 24'hE00400);
        resetN = 1'b0;
        @(negedge clk);
        checkOutput("rst.ramCs", ramCs, 0);
        checkOutput("rst.ramWe", ramWe, 0);
        checkOutput("rst.cpuAck", cpuAck, 0);
        checkOutput("rst.ramAddr", ramAddr, 0);
        resetN = 1'b1;
        v = '{1'b1, 24'h000400, 8'h41, 8'h00, 8'h00, 3, 2, 24'hE00400};
        applyStimulus(v, ob);
        checkCpu("rst.retry", v, ob);

        // Randomized single transactions against the range model.
        $display("[TB] randomized transactions");
        presetAddr = 24'hFFFFFF;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                va = 17'($urandom_range(0, 17'h1FFFF));
                applyVideo(va, ob);
                checkVid($sformatf("rndVid%0d", i), va, ob);
            end else begin
                ra[23:16] = banks[$urandom_range(0, 4)];
                ra[15:0]  = ($urandom_range(0, 1) == 1) ? offs[$urandom_range(0, 17)]
                                                        : 16'($urandom_range(0, 16'hFFFF));
                v = modelVec(($urandom_range(0, 9) < 7), ra, 8'($urandom_range(0, 255)),
                             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                applyStimulus(v, ob);
                checkCpu($sformatf("rndCpu%0d", i), v, ob);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
